alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencing stage that sits directly upstream of the 32-bit structural ALU (3-bit opcode, 32-bit result, ZERO flag) and also captures its output. It accepts one operation per valid/ready handshake and holds registered operands and opcode steady on the ALU inputs for a programmable number of settle cycles, covering the ripple-adder multicycle path. It then captures result and ZERO into an output register offered downstream with valid/ready.

Parameters:
EXEC_CYCLES, 2, cycles operands are held on the ALU before the result is sampled; legal range 1..15.
TAG_W, 4, width of the opaque tag carried from input to output.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept an op
in_a  input  32  operand A
in_b  input  32  operand B
in_op  input  3  ALU opcode: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SUB, 5 SRL, 6 SLL, 7 NOR
in_tag  input  TAG_W  opaque tag
alu_a  output  32  registered operand A to ALU
alu_b  output  32  registered operand B to ALU
alu_op  output  3  registered opcode to ALU
alu_result  input  32  ALU combinational result
alu_zero  input  1  ALU ZERO flag
out_valid  output  1  captured result valid
out_ready  input  1  downstream accepts result
out_result  output  32  captured result
out_zero  output  1  captured ZERO
out_tag  output  TAG_W  tag of the captured op

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, cnt=0, alu_a/alu_b/alu_op=0, out_valid=0, out_result=0, out_zero=0, out_tag=0. in_ready is forced 0 while rst_n is low.
- States: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is a combinational state decode and never depends on in_valid.
- Accept = in_valid && in_ready at a rising edge. On accept: alu_a<=in_a, alu_b<=in_b, alu_op<=in_op, tag_q<=in_tag, cnt<=EXEC_CYCLES-1, state<=EXEC.
- EXEC: alu_* are stable. If cnt!=0, cnt<=cnt-1. If cnt==0: out_result<=alu_result, out_zero<=alu_zero, out_tag<=tag_q, out_valid<=1, state<=DONE.
- Latency: out_valid rises exactly EXEC_CYCLES edges after the accept edge (EXEC_CYCLES=2 gives accept at edge k, out_valid high after edge k+2).
- DONE: out_* are held stable while out_valid=1 && !out_ready.
  - If out_ready && !in_valid: out_valid<=0, state<=IDLE.
  - If out_ready && in_valid: the output handshake and a new accept occur at the same edge. out_valid<=0, operands load, state<=EXEC.
- Sustained throughput: one op per EXEC_CYCLES+1 cycles.
- alu_a/alu_b/alu_op retain their last values in IDLE and DONE; they change only on accept.
- out_result/out_zero/out_tag retain their values after handshake until the next capture.
- in_* are ignored whenever in_ready=0, even if in_valid=1. No op is dropped or duplicated.
- Reset asserted mid-EXEC or in DONE: the in-flight op is discarded and no out_valid is produced after release.
- All 8 opcodes are legal; the block does not interpret in_op.

Optional Feature:
ALU_ISSUE_STATS_EN
- Defined: adds output port op_count (32 bits), reset to 0. It increments by 1 on each output handshake (out_valid && out_ready) and wraps 0xFFFFFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, then ADD a=5 b=7 with out_ready=1 (EXEC_CYCLES=2), ALU model attached -> out_valid pulses 2 edges after accept; out_result=12, out_zero=0, tag echoed.
- SUB a=0x00000009 b=0x00000009 -> out_result=0, out_zero=1; NOR a=0 b=0 -> out_result=0xFFFFFFFF, out_zero=0.
- Backpressure: result ready, out_ready=0 for 5 cycles -> out_valid stays 1, out_* stable, in_ready=0, alu_* unchanged; out_ready=1 -> handshake, in_ready=1 in the same cycle.
- Back-to-back: 4 ops with in_valid and out_ready held high -> one result every 3 cycles in order (tags 0,1,2,3). A new accept occurs on the same edge as each output handshake.
- rst_n pulsed low for 1 cycle mid-EXEC -> outputs zero asynchronously and in_ready=0 during reset; no out_valid afterward; the next op completes normally.
- With ALU_ISSUE_STATS_EN: 3 completed ops -> op_count=3; ops stalled in DONE with out_ready=0 are not counted until handshake.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/capture stage wrapped around the 32-bit ALU.
// It accepts one op per valid/ready handshake, holds the operands steady on
// the ALU for EXEC_CYCLES cycles so the ripple adder can settle, then captures
// the result, ZERO flag and tag into an output register offered downstream.
// Optional build macro ALU_ISSUE_STATS_EN adds op_count, a wrapping counter
// of completed output handshakes.
module alu_issue_ctrl #(
   parameter int EXEC_CYCLES = 2,   // settle cycles, legal 1..15
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_op,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0]      op_count
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   // Countdown starts at EXEC_CYCLES-1 so capture lands exactly EXEC_CYCLES
   // edges after the accept edge.
   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t             state_reg;
   logic [3:0]         cnt_reg;
   logic [31:0]        alu_a_reg;
   logic [31:0]        alu_b_reg;
   logic [2:0]         alu_op_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic               out_valid_reg;
   logic [31:0]        out_result_reg;
   logic               out_zero_reg;
   logic [TAG_W-1:0]   out_tag_reg;
   logic               accept;

   // Ready is a pure state decode; held low while reset is asserted.
   always_comb begin
      in_ready = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
      accept   = in_valid && in_ready;
   end

   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign alu_op     = alu_op_reg;
   assign out_valid  = out_valid_reg;
   assign out_result = out_result_reg;
   assign out_zero   = out_zero_reg;
   assign out_tag    = out_tag_reg;

   // Control FSM with registered ALU operands and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_op_reg     <= '0;
         tag_reg        <= '0;
         out_valid_reg  <= 1'b0;
         out_result_reg <= '0;
         out_zero_reg   <= 1'b0;
         out_tag_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: ;
            EXEC: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  out_result_reg <= alu_result;
                  out_zero_reg   <= alu_zero;
                  out_tag_reg    <= tag_reg;
                  out_valid_reg  <= 1'b1;
                  state_reg      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
         // An accept (from IDLE, or from DONE overlapping the output
         // handshake) overrides the next state chosen above.
         if (accept) begin
            alu_a_reg  <= in_a;
            alu_b_reg  <= in_b;
            alu_op_reg <= in_op;
            tag_reg    <= in_tag;
            cnt_reg    <= CNT_LOAD;
            state_reg  <= EXEC;
         end
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] op_count_reg;
   assign op_count = op_count_reg;

   // Counts completed output handshakes; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_reg <= '0;
      end else if (out_valid_reg && out_ready) begin
         op_count_reg <= op_count_reg + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: table-driven vectors, hand-written
// backpressure / back-to-back / reset sequences, and a randomized run
// checked against an abstract occupancy-and-timer model with a scoreboard.
module tb_alu_issue_ctrl;

   localparam int EXEC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic [2:0]  in_op;
   logic [3:0]  in_tag;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic [3:0]  out_tag;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] op_count;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int hs_count = 0;
   logic [31:0] m_last_a = '0, m_last_b = '0;
   logic [2:0]  m_last_op = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU attached to the DUT and used as the reference.
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd3: return a ^ b;
         3'd4: return a - b;
         3'd5: return a >> b[4:0];
         3'd6: return a << b[4:0];
         default: return ~(a | b);
      endcase
   endfunction

   assign alu_result = alu_ref(alu_a, alu_b, alu_op);
   assign alu_zero   = (alu_result == 32'd0);

   alu_issue_ctrl #(.EXEC_CYCLES(EXEC), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag)
`ifdef ALU_ISSUE_STATS_EN
      , .op_count(op_count)
`endif
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [3:0]  tag;
      logic [31:0] res;
      logic        zero;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [3:0]  tag;
   } exp_t;

   vec_t vecs[10];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One op with out_ready high; checks accept, latency and captured values.
   task automatic run_op(input vec_t v);
      int n;
      int acc_edge;
      @(posedge clk); #1;
      in_a = v.a; in_b = v.b; in_op = v.op; in_tag = v.tag;
      in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check("accept_timeout", 32'(n < 20), 32'd1);
      acc_edge = cyc + 1;
      m_last_a = v.a; m_last_b = v.b; m_last_op = v.op;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("latency", 32'(cyc - acc_edge), 32'(EXEC));
      check("result", out_result, v.res);
      check("zero", 32'(out_zero), 32'(v.zero));
      check("tag", 32'(out_tag), 32'(v.tag));
      hs_count++;
      $display("[TB] op=%0d a=%h b=%h -> result=%h zero=%b tag=%h",
               v.op, v.a, v.b, out_result, out_zero, out_tag);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      int nout;
      int idx;
      logic acc;
      logic hs;
      int t_out[4];
      logic m_has, m_rdy;
      int m_rem;
      exp_t e;
      vec_t v;

      vecs[0] = '{32'd5,         32'd7,         3'd2, 4'h1, 32'd12,        1'b0};
      vecs[1] = '{32'h00000009,  32'h00000009,  3'd4, 4'h2, 32'd0,         1'b1};
      vecs[2] = '{32'd0,         32'd0,         3'd7, 4'h3, 32'hFFFFFFFF,  1'b0};
      vecs[3] = '{32'hF0F0F0F0,  32'h0FF00FF0,  3'd0, 4'h4, 32'h00F000F0,  1'b0};
      vecs[4] = '{32'h00001234,  32'h56780000,  3'd1, 4'h5, 32'h56781234,  1'b0};
      vecs[5] = '{32'hAAAAAAAA,  32'hFFFFFFFF,  3'd3, 4'h6, 32'h55555555,  1'b0};
      vecs[6] = '{32'h80000000,  32'd31,        3'd5, 4'h7, 32'h00000001,  1'b0};
      vecs[7] = '{32'h00000001,  32'd4,         3'd6, 4'h8, 32'h00000010,  1'b0};
      vecs[8] = '{32'hFFFFFFFF,  32'd1,         3'd2, 4'h9, 32'h00000000,  1'b1};
      vecs[9] = '{32'h80000001,  32'd1,         3'd6, 4'hA, 32'h00000002,  1'b0};

      // ---- reset state ----
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef ALU_ISSUE_STATS_EN
      check("rst_op_count", op_count, 32'd0);
`endif
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // ---- table-driven vectors ----
      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      // ---- backpressure: result held while out_ready=0, inputs ignored ----
      @(posedge clk); #1;
      in_a = 32'h00001234; in_b = 32'h00000001; in_op = 3'd3; in_tag = 4'hD;
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      check("bp_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_a = 32'hDEADBEEF; in_b = 32'h0BADF00D; in_op = 3'd2; in_tag = 4'hE;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("bp_valid_timeout", 32'(n < 20), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_result", out_result, 32'h00001235);
         check("bp_out_tag", 32'(out_tag), 32'hD);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_alu_a", alu_a, 32'h00001234);
`ifdef ALU_ISSUE_STATS_EN
         check("bp_op_count", op_count, 32'(hs_count));
`endif
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      hs_count++;
      $display("[TB] backpressure op tag=%h result=%h released", out_tag, out_result);
      @(negedge clk);
      check("bp_after_valid", 32'(out_valid), 32'd0);
      check("bp_after_hold", out_result, 32'h00001235);

      // ---- back-to-back: 4 ops, in_valid and out_ready held high ----
      idx = 0; nout = 0;
      @(posedge clk); #1;
      in_a = 32'd1; in_b = 32'd0; in_op = 3'd2; in_tag = 4'd0; in_valid = 1'b1;
      for (int c = 0; c < 40 && nout < 4; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid) begin
            check("b2b_tag", 32'(out_tag), 32'(nout));
            check("b2b_result", out_result, 32'(17 * nout + 1));
            if (nout < 3) check("b2b_overlap_accept", 32'(acc), 32'd1);
            t_out[nout] = cyc;
            $display("[TB] b2b result tag=%h result=%h cycle=%0d", out_tag, out_result, cyc);
            nout++;
            hs_count++;
         end
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               in_a = 32'(16 * idx + 1); in_b = 32'(idx); in_tag = 4'(idx);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("b2b_count", 32'(nout), 32'd4);
      for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(t_out[i] - t_out[i-1]), 32'(EXEC + 1));
      m_last_a = 32'd49; m_last_b = 32'd3; m_last_op = 3'd2;

      // ---- reset pulse mid-EXEC ----
      @(posedge clk); #1;
      in_a = 32'd3; in_b = 32'd4; in_op = 3'd2; in_tag = 4'hC; in_valid = 1'b1;
      @(negedge clk);
      check("mid_rst_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_alu_a", alu_a, 32'd0);
      check("mid_rst_out_result", out_result, 32'd0);
      check("mid_rst_out_tag", 32'(out_tag), 32'd0);
      hs_count = 0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_rst_no_valid", 32'(out_valid), 32'd0);
      end
      run_op(vecs[0]);

      // ---- randomized run against an occupancy/timer model ----
      m_has = 1'b0; m_rdy = 1'b0; m_rem = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         check("rnd_in_ready", 32'(in_ready), 32'(!m_has || (m_rdy && out_ready)));
         check("rnd_out_valid", 32'(out_valid), 32'(m_rdy));
         check("rnd_alu_a", alu_a, m_last_a);
         check("rnd_alu_b", alu_b, m_last_b);
         check("rnd_alu_op", 32'(alu_op), 32'(m_last_op));
         if (m_rdy) begin
            if (sb.size() == 0) begin
               check("rnd_sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb[0];
               check("rnd_result", out_result, e.res);
               check("rnd_zero", 32'(out_zero), 32'(e.zero));
               check("rnd_tag", 32'(out_tag), 32'(e.tag));
            end
         end
         acc = in_valid && (!m_has || (m_rdy && out_ready));
         hs  = m_rdy && out_ready;
         @(posedge clk);
         if (hs) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_has = 1'b0; m_rdy = 1'b0;
            hs_count++;
            $display("[TB] rnd result tag=%h result=%h zero=%b", out_tag, out_result, out_zero);
         end
         if (acc) begin
            e.res  = alu_ref(in_a, in_b, in_op);
            e.zero = (e.res == 32'd0);
            e.tag  = in_tag;
            sb.push_back(e);
            m_has = 1'b1; m_rdy = 1'b0; m_rem = EXEC;
            m_last_a = in_a; m_last_b = in_b; m_last_op = in_op;
         end else if (m_has && !m_rdy) begin
            m_rem--;
            if (m_rem == 0) m_rdy = 1'b1;
         end
         #1;
         if (i < 280) begin
            in_valid  = 1'($urandom % 2);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            in_b      = ($urandom % 4 == 0) ? in_a : $urandom;
            in_op     = 3'($urandom % 8);
            in_tag    = 4'($urandom % 16);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
      end
      check("rnd_drained", 32'(sb.size()), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
      @(negedge clk);
      check("op_count_final", op_count, 32'(hs_count));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
